fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register; feeds decode_unit.

---
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and one-entry skid buffer
module fetch_stage #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_npc
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      state;
  logic [31:2] pc;
  logic [31:2] pc_next;
  logic [31:2] skid_pc;
  logic [31:0] skid_instr;
  logic        unused_redirect_bits;

  assign pc_next              = pc + 30'd1;
  assign iREN                 = (state == FETCH) && !RST;
  assign iaddr                = {pc, 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc         <= PC_INIT[31:2];
      state      <= FETCH;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= 32'h0;
      ifid_npc   <= 32'h0;
      skid_instr <= 32'h0;
      skid_pc    <= 30'h0;
    end else if (halt) begin
      state      <= HALTED;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else if (state == HALTED) begin
      state <= HALTED;
    end else if (redirect) begin
      // Any same-cycle hit and any parked skid word belong to the wrong path.
      pc         <= redirect_pc[31:2];
      state      <= FETCH;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      skid_instr <= 32'h0;
      skid_pc    <= 30'h0;
    end else begin
      case (state)
        FETCH: begin
          if (!stall) begin
            if (ihit) begin
              ifid_valid <= 1'b1;
              ifid_instr <= iload;
              ifid_pc    <= {pc, 2'b00};
              ifid_npc   <= {pc_next, 2'b00};
              pc         <= pc_next;
            end else begin
              ifid_valid <= 1'b0;
              ifid_instr <= NOP_INSTR;
            end
          end else if (ihit) begin
            // Park the word so it is never re-requested once the stall clears.
            skid_instr <= iload;
            skid_pc    <= pc;
            pc         <= pc_next;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_valid <= 1'b1;
            ifid_instr <= skid_instr;
            ifid_pc    <= {skid_pc, 2'b00};
            ifid_npc   <= {skid_pc + 30'd1, 2'b00};
            state      <= FETCH;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_npc;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  assign iload = ~iaddr;

  fetch_stage dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_npc(ifid_npc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; halt = 1'b0;
    tick();
    tick();
    chk("rst_iren", iREN, 0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_valid", ifid_valid, 0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc", ifid_pc, 32'h0);
    chk("rst_npc", ifid_npc, 32'h0);

    // 1: streaming hits
    RST = 1'b0; ihit = 1'b1;
    #1;
    chk("t1_iren", iREN, 1);
    chk("t1_iaddr0", iaddr, 32'h0);
    tick();
    chk("t1_iaddr4", iaddr, 32'h4);
    chk("t1_valid", ifid_valid, 1);
    chk("t1_pc", ifid_pc, 32'h0);
    chk("t1_instr", ifid_instr, 32'hFFFF_FFFF);
    chk("t1_npc", ifid_npc, 32'h4);

    // 2: two miss cycles
    ihit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t2_iaddr", iaddr, 32'h4);
      chk("t2_iren", iREN, 1);
      chk("t2_valid", ifid_valid, 0);
      chk("t2_instr", ifid_instr, 32'h0);
    end
    ihit = 1'b1;
    tick();
    chk("t2_pc", ifid_pc, 32'h4);
    chk("t2_instr_hit", ifid_instr, 32'hFFFF_FFFB);
    chk("t2_iaddr8", iaddr, 32'h8);

    // 3: stall while 0x8 hits
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_iren", iREN, 0);
      chk("t3_iaddr", iaddr, 32'hC);
      chk("t3_pc_held", ifid_pc, 32'h4);
      chk("t3_instr_held", ifid_instr, 32'hFFFF_FFFB);
      chk("t3_npc_held", ifid_npc, 32'h8);
    end
    stall = 1'b0;
    tick();
    chk("t3_skid_pc", ifid_pc, 32'h8);
    chk("t3_skid_instr", ifid_instr, 32'hFFFF_FFF7);
    chk("t3_skid_npc", ifid_npc, 32'hC);
    chk("t3_skid_valid", ifid_valid, 1);
    chk("t3_resume_iren", iREN, 1);
    chk("t3_resume_iaddr", iaddr, 32'hC);
    tick();
    chk("t3_next_pc", ifid_pc, 32'hC);
    chk("t3_next_iaddr", iaddr, 32'h10);

    // 4: redirect with simultaneous hit, then redirect from HOLD
    redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    chk("t4_valid", ifid_valid, 0);
    chk("t4_instr", ifid_instr, 32'h0);
    chk("t4_iaddr", iaddr, 32'h40);
    redirect = 1'b0; stall = 1'b1;
    tick();
    chk("t4_hold_iren", iREN, 0);
    chk("t4_hold_iaddr", iaddr, 32'h44);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    chk("t4_redir_iaddr", iaddr, 32'h80);
    chk("t4_redir_iren", iREN, 1);
    chk("t4_redir_valid", ifid_valid, 0);
    redirect = 1'b0; stall = 1'b0;
    tick();
    chk("t4_skid_dropped_pc", ifid_pc, 32'h80);
    chk("t4_skid_dropped_instr", ifid_instr, 32'hFFFF_FF7F);
    chk("t4_after_iaddr", iaddr, 32'h84);

    // 5: halt beats redirect; HALTED sticks until reset
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    chk("t5_iren", iREN, 0);
    chk("t5_valid", ifid_valid, 0);
    chk("t5_instr", ifid_instr, 32'h0);
    chk("t5_iaddr", iaddr, 32'h84);
    halt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t5_halted_iren", iREN, 0);
      chk("t5_halted_valid", ifid_valid, 0);
      chk("t5_halted_iaddr", iaddr, 32'h84);
    end
    redirect = 1'b0; RST = 1'b1;
    tick();
    chk("t5_rst_iren", iREN, 0);
    chk("t5_rst_iaddr", iaddr, 32'h0);
    RST = 1'b0;
    #1;
    chk("t5_rst_release_iren", iREN, 1);

    // 6: PC wraparound
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk("t6_iaddr", iaddr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    chk("t6_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("t6_npc", ifid_npc, 32'h0);
    chk("t6_instr", ifid_instr, 32'h3);
    chk("t6_iaddr_wrap", iaddr, 32'h0);
    stall = 1'b1; ihit = 1'b0;
    tick();
    chk("t6_stall_miss_iaddr", iaddr, 32'h0);
    chk("t6_stall_miss_iren", iREN, 1);
    chk("t6_stall_miss_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("t6_stall_miss_valid", ifid_valid, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
